// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared load-type encodings, widths, entry type and helper
//               functions for the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    typedef struct packed {
        logic [REG_AW-1:0] waddr;
        logic [2:0]        ltype;
        logic [1:0]        off;
    } ld_entry_t;

    // Big-endian lane select: byte 0 lives in rdata[31:24].
    function automatic logic [DATA_W-1:0] ld_extract(
        input logic [2:0]        ltype,
        input logic [1:0]        off,
        input logic [DATA_W-1:0] rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [DATA_W-1:0] res;
        case (off)
            2'd0:    b = rdata[31:24];
            2'd1:    b = rdata[23:16];
            2'd2:    b = rdata[15:8];
            default: b = rdata[7:0];
        endcase
        h = off[1] ? rdata[15:0] : rdata[31:16];
        case (ltype)
            LD_LH:   res = {{16{h[15]}}, h};
            LD_LHU:  res = {16'h0000, h};
            LD_LB:   res = {{24{b[7]}}, b};
            LD_LBU:  res = {24'h000000, b};
            default: res = rdata;
        endcase
        return res;
    endfunction

    function automatic logic addr_hit(
        input logic [REG_AW-1:0] chk,
        input logic [REG_AW-1:0] addr
    );
        return (chk != '0) && (chk == addr);
    endfunction

    function automatic logic hit3(
        input logic [REG_AW-1:0] a,
        input logic [REG_AW-1:0] b,
        input logic [REG_AW-1:0] d,
        input logic [REG_AW-1:0] addr
    );
        return addr_hit(a, addr) | addr_hit(b, addr) | addr_hit(d, addr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_ld_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_ld_queue
// Description : In-order outstanding-load FIFO with per-slot address/valid
//               taps for hazard comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ld_queue
    import wb_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  ld_entry_t                i_entry,
    input  logic                     i_pop,
    output ld_entry_t                o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [QDEPTH*REG_AW-1:0] o_addrs,
    output logic [QDEPTH-1:0]        o_vld
);

    localparam int PW = $clog2(QDEPTH);

    logic [PW:0]  r_wr;
    logic [PW:0]  r_rd;
    logic [PW:0]  w_cnt;
    ld_entry_t    r_mem [QDEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr[PW-1:0]] <= i_entry;
    end

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);
    assign o_head  = r_mem[r_rd[PW-1:0]];
    assign w_cnt   = r_wr - r_rd;

    // A slot is live when its distance from the read pointer is below occupancy.
    generate
        for (genvar i = 0; i < QDEPTH; i++) begin : g_slot
            logic [PW-1:0] w_rel;
            assign w_rel                     = PW'(i) - r_rd[PW-1:0];
            assign o_vld[i]                  = ({1'b0, w_rel} < w_cnt);
            assign o_addrs[i*REG_AW +: REG_AW] = r_mem[i].waddr;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Merges ALU results and in-order load returns onto the single
//               register-file write port and flags decode hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_waddr,
    input  logic [DATA_W-1:0] alu_wdata,
    output logic              alu_ready,
    input  logic              ld_issue,
    input  logic [REG_AW-1:0] ld_waddr,
    input  logic [2:0]        ld_type,
    input  logic [1:0]        ld_off,
    output logic              ld_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [REG_AW-1:0] chk_a,
    input  logic [REG_AW-1:0] chk_b,
    input  logic [REG_AW-1:0] chk_d,
    output logic              stall,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_W_addr,
    output logic [DATA_W-1:0] wdata,
    output logic              proto_err
);

    logic                     w_qfull;
    logic                     w_qempty;
    logic                     w_push;
    logic                     w_pop;
    ld_entry_t                w_entry;
    ld_entry_t                w_head;
    logic [QDEPTH*REG_AW-1:0] w_addrs;
    logic [QDEPTH-1:0]        w_vld;

    logic                     r_hold_valid;
    logic [REG_AW-1:0]        r_hold_addr;
    logic [DATA_W-1:0]        r_hold_data;
    logic                     r_we;
    logic [REG_AW-1:0]        r_waddr;
    logic [DATA_W-1:0]        r_wdata;
    logic                     r_perr;

    logic                     w_alu_acc;
    logic                     w_win_valid;
    logic [REG_AW-1:0]        w_win_addr;
    logic [DATA_W-1:0]        w_win_data;
    logic                     w_hold_set;
    logic                     w_hold_clr;
    logic                     w_perr_set;
    logic                     w_stall;

    // A pop frees a slot in the same cycle, so a push is taken even when full.
    assign w_pop   = mem_rvalid && !w_qempty;
    assign w_push  = ld_issue && (!w_qfull || w_pop);
    assign w_entry = '{waddr: ld_waddr, ltype: ld_type, off: ld_off};

    wb_ld_queue #(
        .QDEPTH (QDEPTH)
    ) u_ld_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_qfull),
        .o_empty (w_qempty),
        .o_addrs (w_addrs),
        .o_vld   (w_vld)
    );

    assign alu_ready  = !r_hold_valid;
    assign ld_ready   = !w_qfull;
    assign w_alu_acc  = alu_valid && !r_hold_valid;
    assign w_perr_set = (ld_issue && w_qfull && !w_pop) || (mem_rvalid && w_qempty);

    always_comb begin
        w_win_valid = 1'b0;
        w_win_addr  = '0;
        w_win_data  = '0;
        w_hold_set  = 1'b0;
        w_hold_clr  = 1'b0;
        if (w_pop) begin
            w_win_valid = 1'b1;
            w_win_addr  = w_head.waddr;
            w_win_data  = ld_extract(w_head.ltype, w_head.off, mem_rdata);
            w_hold_set  = w_alu_acc;
        end else if (r_hold_valid) begin
            w_win_valid = 1'b1;
            w_win_addr  = r_hold_addr;
            w_win_data  = r_hold_data;
            w_hold_clr  = 1'b1;
        end else if (w_alu_acc) begin
            w_win_valid = 1'b1;
            w_win_addr  = alu_waddr;
            w_win_data  = alu_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_data  <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_perr       <= 1'b0;
        end else begin
            if (w_hold_set) begin
                r_hold_valid <= 1'b1;
                r_hold_addr  <= alu_waddr;
                r_hold_data  <= alu_wdata;
            end else if (w_hold_clr) begin
                r_hold_valid <= 1'b0;
            end
            r_we    <= w_win_valid && (w_win_addr != '0);
            r_waddr <= w_win_addr;
            r_wdata <= w_win_data;
            if (w_perr_set) r_perr <= 1'b1;
        end
    end

    always_comb begin
        w_stall = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (w_vld[i] && hit3(chk_a, chk_b, chk_d, w_addrs[i*REG_AW +: REG_AW]))
                w_stall = 1'b1;
        end
        if (r_hold_valid && hit3(chk_a, chk_b, chk_d, r_hold_addr)) w_stall = 1'b1;
        if (r_we && hit3(chk_a, chk_b, chk_d, r_waddr))             w_stall = 1'b1;
    end

    assign stall      = w_stall;
    assign reg_we     = r_we;
    assign reg_W_addr = r_waddr;
    assign wdata      = r_wdata;
    assign proto_err  = r_perr;

endmodule
`default_nettype wire
